single_cycle_u_processor: RTL and testbench
===========================================

Name: single_cycle_u_processor

Overview:
- Minimal single-cycle 32-bit ARM-style processor that operates as a calculator.
- An external host writes an opcode and two operands into the data memory through a write port.
- A fixed program in the instruction ROM loops continuously: it loads the opcode and operands, computes, and publishes the result on resultadoCalcu.
- This block is the top of the ARM_Calculator datapath.

Parameters:
- DMEM_WORDS, 16, data-memory depth in 32-bit words (word index = addressCalcu[5:2]).
- ROM_WORDS, 8, instruction-ROM depth in words.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- EntradaCalcu  in  32  data word the host writes into data memory.
- addressCalcu  in  32  byte address for the host write; word aligned; bits [1:0] and above [5] are ignored.
- writeEnableCalcu  in  1  active-LOW host write strobe (0 = write, 1 = idle).
- resultadoCalcu  out  32  latest computed result (register R4).

Behaviour:
- Reset (RST_N=0, asynchronous): PC, R0-R15, all data-memory words and resultadoCalcu clear to 0 immediately. Execution resumes at PC=0 on the first rising CLK edge after release.
- Host write: on a rising edge with writeEnableCalcu=0, dmem[addressCalcu[5:2]] <= EntradaCalcu. With writeEnableCalcu=1 nothing is written.
- Memory map (byte addresses):
  - 0 = opcode
  - 16 = operand A
  - 20 = operand B
  - 24 = result mirror
  - all other words are free
- Single cycle: exactly one instruction completes per CLK edge. The register file has 2 combinational read ports and 1 write port; R0 is read as 0.
- Instruction format, fields [27:26]:
  - 00 = ALU: I=[25], op=[24:21], Rn=[19:16], Rd=[15:12], src2 = Rm[3:0], or imm8[7:0] zero-extended when I=1.
  - 01 = memory: L=[20] (1 = LDR, 0 = STR), Rn, Rd, imm12[11:0] byte offset; address = Rn + imm12.
  - 10 = branch: PC <= PC + 8 + (sign-extended imm24 << 2).
  - Cond field [31:28] is ignored (always execute). No flags are kept.
- ALU op codes: 0 ADD, 1 SUB (A-B), 2 MUL (low 32 bits), 3 AND, 4 ORR, 5 EOR, 6 LSL (by B[4:0]), 7 LSR (logical, by B[4:0]); 8-14 give 0.
  - Op 15 = dynamic: the effective op is R1[3:0]; if R1 > 7 the result is 0.
  - All arithmetic wraps modulo 2^32.
- Fixed ROM program, PC byte address 0..20:
  - 0: LDR R1,[R0,#0]
  - 4: LDR R2,[R0,#16]
  - 8: LDR R3,[R0,#20]
  - 12: ALU op15, R4 = R2 op R3
  - 16: STR R4,[R0,#24]
  - 20: B to 0
  - Unused ROM words decode as NOP. PC wraps modulo ROM_WORDS*4.
- resultadoCalcu is driven directly from R4. It is updated at the instruction-12 edge.
- Latency: a host write becomes visible on resultadoCalcu no later than 12 CLK edges after the write edge.
- Simultaneous host write and STR to the same word: the host write wins.
- A host write to a word in the same cycle it is loaded: the LDR returns the old value; the new value is picked up next iteration.
- Unaligned addresses: low bits are dropped, never faulted.

Decomposition:
- Package calc_pkg holds:
  - ALU op constants (ALU_ADD .. ALU_LSR, ALU_DYN=15).
  - Instruction class codes.
  - Memory-map constants ADDR_OPCODE=0, ADDR_A=16, ADDR_B=20, ADDR_RES=24.
  - The ROM program as a constant array.
- One sub-module, calc_alu: combinational, inputs a[31:0], b[31:0], op[3:0]; output y[31:0].
- Register file, data memory and ROM stay inline in the top.

Test Plan:
- Hold RST_N=0 -> resultadoCalcu=0 asynchronously. Release with memory at 0 -> result stays 0 (ADD 0+0).
- writeEnableCalcu=0, write 7@16 then 8@20, opcode word left at 0 -> within 12 cycles resultadoCalcu=15.
- writeEnableCalcu=1 with EntradaCalcu=6, addressCalcu=20 for 10 cycles -> no write; resultadoCalcu stays 15.
- Write 2@0 with A=7, B=8 -> resultadoCalcu=56.
- Opcodes over A=7, B=8 -> result per opcode:
  - 1 -> 0xFFFFFFFF
  - 6 -> 0x700
  - 9 -> 0
  - opcode 7 with A=0x80000000, B=31 -> 1
- Assert RST_N=0 mid-loop -> result, registers and memory clear at once. After release with no writes -> result remains 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the ARM-style calculator: ALU op codes, instruction
// classes, memory map and the fixed ROM program.
package calc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_ORR  = 4'd4;
  localparam logic [3:0] ALU_EOR  = 4'd5;
  localparam logic [3:0] ALU_LSL  = 4'd6;
  localparam logic [3:0] ALU_LSR  = 4'd7;
  localparam logic [3:0] ALU_ZERO = 4'd8;
  localparam logic [3:0] ALU_DYN  = 4'd15;

  typedef enum logic [1:0] {
    CLS_ALU = 2'b00,
    CLS_MEM = 2'b01,
    CLS_BR  = 2'b10,
    CLS_NOP = 2'b11
  } instr_class_e;

  localparam logic [31:0] ADDR_OPCODE = 32'd0;
  localparam logic [31:0] ADDR_A      = 32'd16;
  localparam logic [31:0] ADDR_B      = 32'd20;
  localparam logic [31:0] ADDR_RES    = 32'd24;

  localparam logic [31:0] INSTR_NOP = 32'hEC00_0000;

  localparam int PROG_LEN = 6;

  // LDR R1..R3 from the opcode/operand words, R4 = R2 op(R1) R3, mirror R4, loop.
  localparam logic [31:0] ROM_PROG [PROG_LEN] = '{
    32'hE590_1000,
    32'hE590_2010,
    32'hE590_3014,
    32'hE1E2_4003,
    32'hE580_4018,
    32'hEAFF_FFF9
  };

endpackage

// File: rtl/calc_alu.sv
// Combinational calculator ALU; op codes above LSR (including the dynamic
// code, resolved by the caller) produce zero.
module calc_alu
  import calc_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] y
);

  always_comb begin
    y = 32'd0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_MUL: y = a * b;
      ALU_AND: y = a & b;
      ALU_ORR: y = a | b;
      ALU_EOR: y = a ^ b;
      ALU_LSL: y = a << b[4:0];
      ALU_LSR: y = a >> b[4:0];
      default: y = 32'd0;
    endcase
  end

endmodule

// File: rtl/single_cycle_u_processor.sv
// Single-cycle ARM-style calculator core: fixed ROM loop that loads the
// host-written opcode/operands, computes, and exposes R4 as the result.
module single_cycle_u_processor
  import calc_pkg::*;
#(
  parameter int DMEM_WORDS = 16,
  parameter int ROM_WORDS  = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] EntradaCalcu,
  input  logic [31:0] addressCalcu,
  input  logic        writeEnableCalcu,
  output logic [31:0] resultadoCalcu
);

  localparam int DW   = $clog2(DMEM_WORDS);
  localparam int PC_W = $clog2(ROM_WORDS * 4);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     rf_q   [16];
  logic [31:0]     dmem_q [DMEM_WORDS];

  logic [31:0]  rom_idx_s;
  logic [31:0]  instr_s;
  instr_class_e iclass_s;
  logic [3:0]   rn_s, rd_s, rm_s, alu_op_s, eff_op_s;
  logic [31:0]  rn_val_s, rd_val_s, rm_val_s, src2_s, alu_y_s;
  logic [31:0]  mem_addr_s, pc_ext_s, br_target_s;
  logic [DW-1:0] mem_idx_s, host_idx_s;
  logic         rf_we_s, st_we_s;
  logic [31:0]  rf_wdata_s;
  logic         unused_ok;

  assign rom_idx_s = 32'(pc_q[PC_W-1:2]);
  assign instr_s   = (rom_idx_s < 32'(PROG_LEN)) ? ROM_PROG[rom_idx_s[2:0]] : INSTR_NOP;

  assign iclass_s = instr_class_e'(instr_s[27:26]);
  assign alu_op_s = instr_s[24:21];
  assign rn_s     = instr_s[19:16];
  assign rd_s     = instr_s[15:12];
  assign rm_s     = instr_s[3:0];

  assign rn_val_s = (rn_s == 4'd0) ? 32'd0 : rf_q[rn_s];
  assign rd_val_s = (rd_s == 4'd0) ? 32'd0 : rf_q[rd_s];
  assign rm_val_s = (rm_s == 4'd0) ? 32'd0 : rf_q[rm_s];
  assign src2_s   = instr_s[25] ? {24'd0, instr_s[7:0]} : rm_val_s;

  // Dynamic op takes its code from R1; anything beyond LSR yields zero.
  always_comb begin
    eff_op_s = alu_op_s;
    if (alu_op_s == ALU_DYN) begin
      if (rf_q[1] > 32'd7) begin
        eff_op_s = ALU_ZERO;
      end else begin
        eff_op_s = rf_q[1][3:0];
      end
    end else begin
      eff_op_s = alu_op_s;
    end
  end

  calc_alu u_alu (
    .a  (rn_val_s),
    .b  (src2_s),
    .op (eff_op_s),
    .y  (alu_y_s)
  );

  assign mem_addr_s  = rn_val_s + {20'd0, instr_s[11:0]};
  assign mem_idx_s   = mem_addr_s[DW+1:2];
  assign host_idx_s  = addressCalcu[DW+1:2];
  assign pc_ext_s    = 32'(pc_q);
  assign br_target_s = pc_ext_s + 32'd8 + {{6{instr_s[23]}}, instr_s[23:0], 2'b00};

  // Instruction execute: register write-back, store strobe and next PC.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wdata_s = 32'd0;
    st_we_s    = 1'b0;
    pc_d       = pc_q + PC_W'(4);
    case (iclass_s)
      CLS_ALU: begin
        rf_we_s    = (rd_s != 4'd0);
        rf_wdata_s = alu_y_s;
      end
      CLS_MEM: begin
        if (instr_s[20]) begin
          rf_we_s    = (rd_s != 4'd0);
          rf_wdata_s = dmem_q[mem_idx_s];
        end else begin
          st_we_s = 1'b1;
        end
      end
      CLS_BR: begin
        pc_d = br_target_s[PC_W-1:0];
      end
      default: begin
        rf_we_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (rf_we_s) begin
      rf_q[rd_s] <= rf_wdata_s;
    end
  end

  // Host write is issued last so it wins over a same-edge STR to the same word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem_q[i] <= 32'd0;
      end
    end else begin
      if (st_we_s) begin
        dmem_q[mem_idx_s] <= rd_val_s;
      end
      if (!writeEnableCalcu) begin
        dmem_q[host_idx_s] <= EntradaCalcu;
      end
    end
  end

  assign resultadoCalcu = rf_q[4];

  assign unused_ok = ^{instr_s[31:28], mem_addr_s, addressCalcu, br_target_s};

endmodule

// File: tb/tb_single_cycle_u_processor.sv
// Randomized self-checking bench: host writes drive a memory-image model whose
// expected result is computed from the calculator rules.
module tb_single_cycle_u_processor;

  logic        CLK;
  logic        RST_N;
  logic [31:0] EntradaCalcu;
  logic [31:0] addressCalcu;
  logic        writeEnableCalcu;
  logic [31:0] resultadoCalcu;

  int n_checks;
  int n_errors;
  logic [31:0] mem_m [16];

  single_cycle_u_processor dut (
    .CLK              (CLK),
    .RST_N            (RST_N),
    .EntradaCalcu     (EntradaCalcu),
    .addressCalcu     (addressCalcu),
    .writeEnableCalcu (writeEnableCalcu),
    .resultadoCalcu   (resultadoCalcu)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_calc(input logic [31:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    if (op > 32'd7) return 32'd0;
    case (op)
      32'd0:   r = a + b;
      32'd1:   r = a - b;
      32'd2:   r = a * b;
      32'd3:   r = a & b;
      32'd4:   r = a | b;
      32'd5:   r = a ^ b;
      32'd6:   r = a << (b % 32);
      32'd7:   r = a >> (b % 32);
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] expected_result();
    return ref_calc(mem_m[0], mem_m[4], mem_m[5]);
  endfunction

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Host write with optional garbage in the ignored address bits.
  task automatic host_write(input logic [31:0] word, input logic [31:0] data, input bit junk);
    logic [31:0] addr;
    addr = (word % 32'd16) * 32'd4;
    if (junk) addr = addr | ($urandom & 32'hFFFF_FFC0) | ($urandom & 32'h0000_0003);
    addressCalcu     = addr;
    EntradaCalcu     = data;
    writeEnableCalcu = 1'b0;
    @(posedge CLK);
    #1;
    writeEnableCalcu = 1'b1;
    mem_m[word % 32'd16] = data;
  endtask

  task automatic set_calc(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit junk);
    host_write(32'd0, op, junk);
    host_write(32'd4, a, junk);
    host_write(32'd5, b, junk);
    cycles(12);
  endtask

  initial begin
    logic [31:0] op, a, b, w;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
    EntradaCalcu     = 32'd0;
    addressCalcu     = 32'd0;
    writeEnableCalcu = 1'b1;
    RST_N            = 1'b1;
    #1 RST_N = 1'b0;
    #2;
    chk_eq("reset_async", resultadoCalcu, 32'd0);
    cycles(2);
    chk_eq("reset_held", resultadoCalcu, 32'd0);
    #3 RST_N = 1'b1;
    cycles(12);
    chk_eq("zero_mem_add", resultadoCalcu, 32'd0);

    host_write(32'd4, 32'd7, 1'b0);
    host_write(32'd5, 32'd8, 1'b0);
    cycles(12);
    chk_eq("add_7_8", resultadoCalcu, 32'd15);

    EntradaCalcu     = 32'd6;
    addressCalcu     = 32'd20;
    writeEnableCalcu = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      chk_eq("we_idle", resultadoCalcu, 32'd15);
    end

    set_calc(32'd2, 32'd7, 32'd8, 1'b0);
    chk_eq("mul_7_8", resultadoCalcu, 32'd56);
    set_calc(32'd1, 32'd7, 32'd8, 1'b0);
    chk_eq("sub_7_8", resultadoCalcu, 32'hFFFF_FFFF);
    set_calc(32'd6, 32'd7, 32'd8, 1'b0);
    chk_eq("lsl_7_8", resultadoCalcu, 32'h0000_0700);
    set_calc(32'd9, 32'd7, 32'd8, 1'b0);
    chk_eq("op9_zero", resultadoCalcu, 32'd0);
    set_calc(32'd7, 32'h8000_0000, 32'd31, 1'b0);
    chk_eq("lsr_31", resultadoCalcu, 32'd1);
    set_calc(32'd15, 32'd7, 32'd8, 1'b0);
    chk_eq("op15_zero", resultadoCalcu, 32'd0);

    for (int it = 0; it < 30; it++) begin
      w = $urandom_range(1, 15);
      if (w == 32'd4 || w == 32'd5) w = 32'd9;
      host_write(w, $urandom, 1'b1);
      op = $urandom_range(0, 12);
      if (op > 32'd9) op = $urandom;
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      set_calc(op, a, b, 1'b1);
      chk_eq($sformatf("rand_op%0d", op), resultadoCalcu, expected_result());
    end

    set_calc(32'd0, 32'd3, 32'd4, 1'b0);
    chk_eq("pre_reset", resultadoCalcu, 32'd7);
    cycles(3);
    #2 RST_N = 1'b0;
    #1;
    chk_eq("midloop_reset_async", resultadoCalcu, 32'd0);
    for (int i = 0; i < 16; i++) mem_m[i] = 32'd0;
    cycles(2);
    RST_N = 1'b1;
    cycles(14);
    chk_eq("after_reset_idle", resultadoCalcu, 32'd0);

    host_write(32'd5, 32'd5, 1'b0);
    cycles(12);
    chk_eq("mem_cleared", resultadoCalcu, expected_result());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
